pipe_spawner: RTL and testbench
===============================

// Module: pipe_spawner
// PURPOSE
//  Consumer of the free-running 10-bit LFSR random number. Owns the scrolling
//  obstacle (pipe) list for the Flappy Bird game.
//  - Spawns pipes at the right screen edge with a random gap height.
//  - Scrolls the pipes left on each scroll tick and retires them at the left edge.
//  - Counts score as pipes pass the bird.
//  - Feeds the renderer and the collision checker.
// PARAMETERS
//  NPIPE     4    number of pipe slots
//  SCREEN_W  640  spawn x coordinate (left edge of a new pipe)
//  PIPE_W    52   pipe width in px
//  SPEED     2    px moved per scroll_tick
//  SPACING   110  scroll ticks between spawns
//  GAP_MIN   80   minimum gap_top y
//  GAP_H     120  gap height; constraint: GAP_MIN+255+GAP_H <= screen height
//  BIRD_X    160  bird x coordinate used for scoring
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous, active-high reset
//  start        in   1         1-cycle pulse: clear pipes/score, enter RUN
//  game_over    in   1         level: freeze the field
//  scroll_tick  in   1         1-cycle pulse, frame-rate movement strobe
//  rand_num     in   10        LFSR output, sampled only in the spawn cycle
//  pipe_valid   out  NPIPE     slot i holds a live pipe
//  pipe_x       out  NPIPE*11  left edge x per slot; slot i = [11*i +: 11]
//  pipe_gap_top out  NPIPE*10  gap top y per slot; gap bottom = top+GAP_H
//  score        out  10        pipes passed, saturates at 999
//  score_pulse  out  1         1-cycle pulse per scoring cycle
//  running      out  1         high in RUN
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; spawn_cnt=SPACING; scored flags 0.
//  FSM states:
//   IDLE   -> RUN on start.
//   RUN    -> FROZEN on game_over.
//   FROZEN -> RUN on start.
//   Every start (from IDLE or FROZEN) clears valid, scored and score, and
//   presets spawn_cnt=SPACING. start while in RUN is ignored.
//  RUN, on scroll_tick (all updates in the same cycle, registered, 1-cycle latency):
//   - Each valid pipe with x >= SPEED: x <= x-SPEED.
//     A valid pipe with x < SPEED is retired (valid <= 0).
//   - Score: if the pipe is not yet scored, x+PIPE_W >= BIRD_X (old value) and
//     x-SPEED+PIPE_W < BIRD_X (new value), set its scored flag.
//     score += number of pipes newly scored this cycle (saturating at 999).
//     score_pulse = 1 if any pipe scored.
//   - Spawn: if spawn_cnt == SPACING and a free slot exists, take the lowest-index
//     slot that is invalid after this cycle's retirement:
//     x=SCREEN_W, gap_top=GAP_MIN+rand_num[7:0], scored=0, spawn_cnt<=1.
//     If no slot is free, spawn_cnt holds at SPACING and the spawn happens on the
//     first later tick with a free slot. Otherwise spawn_cnt+1.
//   - The first tick after start spawns immediately (counter preset).
//  No scroll_tick: everything holds.
//  game_over and scroll_tick in the same cycle: game_over wins, no movement.
//  FROZEN/IDLE: positions, score and valid hold (renderer keeps drawing the scene).
//  rst mid-RUN: immediate return to reset values next cycle.
//  Widths: x is 11-bit unsigned (never negative); gap_top is 10-bit.
// STRUCTURE
//  Shared package (flappy_pkg): SCREEN_W, PIPE_W, GAP_H, BIRD_X and the state
//  encoding {IDLE=2'd0, RUN=2'd1, FROZEN=2'd2}, shared with the renderer and
//  collision logic.
//  One sub-module: pipe_slot, instantiated NPIPE times.
//   - Owns x, gap_top, valid and scored for one slot.
//   - Inputs: move, load, clear.
//   - Outputs: retire_next, score_hit.
//  Top level holds the FSM, spawn counter, free-slot priority encoder and score
//  adder.
// TESTING
//  1 rst, start, then scroll_tick with rand_num=10'h3C5 -> slot0 valid,
//    x=640, gap_top=80+0xC5=277, score=0.
//  2 Run 110 ticks with rand_num=10'h005 -> slot1 spawns on tick 111,
//    gap_top=85, x=640; slot0 x=420.
//  3 Track slot0 until x+52 < 160 -> one score_pulse on that tick, score=1,
//    no second pulse on later ticks.
//  4 SPACING=20 override, run long -> at most 4 valid at once; spawn delayed
//    until a retirement; a slot retires exactly when x < 2.
//  5 game_over with scroll_tick in the same cycle -> no movement, FROZEN; 50 ticks
//    -> state unchanged; start -> all valid=0, score=0, spawn on next tick.
//  6 rst asserted mid-RUN with 3 pipes live -> next cycle all outputs 0,
//    running=0.

Source files
------------

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared constants for the Flappy Bird game blocks (spawner,
//                renderer, collision checker). Holds the screen/pipe geometry,
//                the bird scoring column, the score ceiling and the game-state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    // Geometry shared with the renderer and the collision checker
    localparam int SCREEN_W  = 640;
    localparam int PIPE_W    = 52;
    localparam int GAP_H     = 120;
    localparam int BIRD_X    = 160;

    // Score display is three decimal digits
    localparam int SCORE_MAX = 999;

    // Game state encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_FROZEN = 2'd2;

    // Saturating add of a small increment onto a 10-bit score
    function automatic logic [9:0] score_add(input logic [9:0] score,
                                             input logic [9:0] inc);
        logic [10:0] sum;
        sum = {1'b0, score} + {1'b0, inc};
        if (sum > 11'(SCORE_MAX)) begin
            return 10'(SCORE_MAX);
        end
        return sum[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_spawner_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_spawner_if
//  Description : Control inputs and pipe-field outputs of the pipe spawner.
//                slave  - seen by pipe_spawner (controls in, field out)
//                master - seen by the game controller / test driver
//  Ports       : start, game_over, scroll_tick, rand_num[9:0]      (to DUT)
//                pipe_valid[NPIPE], pipe_x[NPIPE*11],
//                pipe_gap_top[NPIPE*10], score[9:0], score_pulse,
//                running                                          (from DUT)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_spawner_if #(
    parameter int NPIPE = 4
);
    logic                  start;
    logic                  game_over;
    logic                  scroll_tick;
    logic [9:0]            rand_num;
    logic [NPIPE-1:0]      pipe_valid;
    logic [NPIPE*11-1:0]   pipe_x;
    logic [NPIPE*10-1:0]   pipe_gap_top;
    logic [9:0]            score;
    logic                  score_pulse;
    logic                  running;

    modport slave (
        input  start, game_over, scroll_tick, rand_num,
        output pipe_valid, pipe_x, pipe_gap_top, score, score_pulse, running
    );

    modport master (
        output start, game_over, scroll_tick, rand_num,
        input  pipe_valid, pipe_x, pipe_gap_top, score, score_pulse, running
    );
endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One obstacle slot. Holds left-edge x, gap top, valid and
//                scored. Moves left by SPEED on move, retires when it can no
//                longer move, reloads at the right edge on load.
//  Ports       : clk, rst         clock / synchronous active-high reset
//                clear            drop the pipe (new game)
//                move             scroll strobe for this cycle
//                load, gap_in     spawn a new pipe with this gap top
//                valid, x, gap_top  slot contents
//                retire_next      slot is free after this cycle's move
//                score_hit        this move carries the pipe past the bird
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int SCREEN_W = 640,
    parameter int PIPE_W   = 52,
    parameter int SPEED    = 2,
    parameter int BIRD_X   = 160
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    input  wire logic        move,
    input  wire logic        load,
    input  wire logic [9:0]  gap_in,
    output logic             valid,
    output logic [10:0]      x,
    output logic [9:0]       gap_top,
    output logic             retire_next,
    output logic             score_hit
);

    logic        r_valid;
    logic        r_scored;
    logic [10:0] r_x;
    logic [9:0]  r_gap_top;

    // Right edge before and after the move, one extra bit so x+PIPE_W
    // cannot wrap near the spawn column.
    logic [11:0] w_right_old;
    logic [11:0] w_right_new;

    assign w_right_old = {1'b0, r_x} + 12'(PIPE_W);
    assign w_right_new = w_right_old - 12'(SPEED);

    assign retire_next = r_valid && (r_x < 11'(SPEED));

    // A retiring pipe never scores: its right edge is already left of the bird.
    assign score_hit = r_valid && !r_scored && !retire_next &&
                       (w_right_old >= 12'(BIRD_X)) &&
                       (w_right_new <  12'(BIRD_X));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_scored  <= 1'b0;
            r_x       <= '0;
            r_gap_top <= '0;
        end else if (clear) begin
            r_valid  <= 1'b0;
            r_scored <= 1'b0;
        end else if (load) begin
            // load only targets a slot that is empty after this cycle's move
            r_valid   <= 1'b1;
            r_scored  <= 1'b0;
            r_x       <= 11'(SCREEN_W);
            r_gap_top <= gap_in;
        end else if (move && r_valid) begin
            if (retire_next) begin
                r_valid <= 1'b0;
            end else begin
                r_x <= r_x - 11'(SPEED);
            end
            if (score_hit) begin
                r_scored <= 1'b1;
            end
        end
    end

    assign valid   = r_valid;
    assign x       = r_x;
    assign gap_top = r_gap_top;

endmodule
`default_nettype wire

// File: rtl/pipe_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_spawner
//  Description : Owns the scrolling pipe list of the Flappy Bird game. Spawns
//                pipes at the right edge with a random gap, scrolls them on
//                scroll_tick, retires them at the left edge and counts score
//                as pipes pass the bird.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                bus        pipe_spawner_if.slave (controls in, field out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_spawner #(
    parameter int NPIPE    = 4,
    parameter int SCREEN_W = flappy_pkg::SCREEN_W,
    parameter int PIPE_W   = flappy_pkg::PIPE_W,
    parameter int SPEED    = 2,
    parameter int SPACING  = 110,
    parameter int GAP_MIN  = 80,
    parameter int GAP_H    = flappy_pkg::GAP_H,
    parameter int BIRD_X   = flappy_pkg::BIRD_X
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_spawner_if.slave     bus
);
    import flappy_pkg::*;

    localparam int c_CNT_W = $clog2(SPACING + 1);
    localparam int c_NW    = $clog2(NPIPE + 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_spawn_cnt;
    logic [9:0]          r_score;
    logic                r_score_pulse;

    logic                w_start_ok;
    logic                w_tick;
    logic                w_cnt_full;
    logic                w_spawn;
    logic [NPIPE-1:0]    w_valid;
    logic [NPIPE-1:0]    w_retire;
    logic [NPIPE-1:0]    w_hit;
    logic [NPIPE-1:0]    w_free;
    logic [NPIPE-1:0]    w_lowest;
    logic [NPIPE-1:0]    w_load;
    logic [9:0]          w_gap;
    logic [c_NW-1:0]     w_nhit;
    logic [1:0]          w_unused_rand;

    // GAP_H only constrains the screen layout; the gap bottom is derived
    // downstream as gap_top + GAP_H.
    assign w_unused_rand = bus.rand_num[9:8];

    // start restarts the game from IDLE or FROZEN; ignored while running
    assign w_start_ok = bus.start && (r_state != c_RUN);
    // game_over wins over a simultaneous scroll_tick
    assign w_tick     = (r_state == c_RUN) && bus.scroll_tick && !bus.game_over;
    assign w_cnt_full = (r_spawn_cnt == c_CNT_W'(SPACING));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (bus.start)     w_state_nxt = c_RUN;
            c_RUN:    if (bus.game_over) w_state_nxt = c_FROZEN;
            c_FROZEN: if (bus.start)     w_state_nxt = c_RUN;
            default:                     w_state_nxt = c_IDLE;
        endcase
    end

    // Free-slot search sees this cycle's retirements, so a pipe leaving the
    // left edge can hand its slot straight to the new spawn.
    assign w_free   = ~w_valid | w_retire;
    assign w_lowest = w_free & (~w_free + NPIPE'(1));
    assign w_spawn  = w_tick && w_cnt_full && (|w_free);
    assign w_load   = w_spawn ? w_lowest : '0;
    assign w_gap    = 10'(GAP_MIN) + {2'b00, bus.rand_num[7:0]};
    assign w_nhit   = c_NW'($countones(w_hit));

    generate
        for (genvar gi = 0; gi < NPIPE; gi++) begin : g_slot
            pipe_slot #(
                .SCREEN_W (SCREEN_W),
                .PIPE_W   (PIPE_W),
                .SPEED    (SPEED),
                .BIRD_X   (BIRD_X)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .clear       (w_start_ok),
                .move        (w_tick),
                .load        (w_load[gi]),
                .gap_in      (w_gap),
                .valid       (w_valid[gi]),
                .x           (bus.pipe_x[11*gi +: 11]),
                .gap_top     (bus.pipe_gap_top[10*gi +: 10]),
                .retire_next (w_retire[gi]),
                .score_hit   (w_hit[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_spawn_cnt   <= c_CNT_W'(SPACING);
            r_score       <= '0;
            r_score_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_score_pulse <= w_tick && (|w_hit);
            if (w_start_ok) begin
                r_spawn_cnt <= c_CNT_W'(SPACING);
                r_score     <= '0;
            end else if (w_tick) begin
                r_score <= score_add(r_score, 10'(w_nhit));
                if (w_cnt_full) begin
                    // with no free slot the counter parks at SPACING
                    if (|w_free) begin
                        r_spawn_cnt <= c_CNT_W'(1);
                    end
                end else begin
                    r_spawn_cnt <= r_spawn_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign bus.pipe_valid  = w_valid;
    assign bus.score       = r_score;
    assign bus.score_pulse = r_score_pulse;
    assign bus.running     = (r_state == c_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_spawner
//  Description : Directed self-checking bench for pipe_spawner. Instance
//                dut uses the default SPACING=110, dut20 uses SPACING=20 to
//                fill every slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_spawner;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pipe_spawner_if #(.NPIPE(4)) ifa ();
    pipe_spawner_if #(.NPIPE(4)) ifb ();

    pipe_spawner #(.NPIPE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pipe_spawner #(.NPIPE(4), .SPACING(20)) dut20 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xa(input int i);
        return 32'(ifa.pipe_x[11*i +: 11]);
    endfunction
    function automatic logic [31:0] ga(input int i);
        return 32'(ifa.pipe_gap_top[10*i +: 10]);
    endfunction
    function automatic logic [31:0] xb(input int i);
        return 32'(ifb.pipe_x[11*i +: 11]);
    endfunction
    function automatic logic [31:0] gb(input int i);
        return 32'(ifb.pipe_gap_top[10*i +: 10]);
    endfunction

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_a(input int n);
        for (int k = 0; k < n; k++) begin
            ifa.scroll_tick = 1'b1;
            @(posedge clk);
            #1;
            ifa.scroll_tick = 1'b0;
        end
    endtask

    task automatic tick_b(input int n);
        for (int k = 0; k < n; k++) begin
            ifb.scroll_tick = 1'b1;
            @(posedge clk);
            #1;
            ifb.scroll_tick = 1'b0;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.game_over = 1'b0; ifa.scroll_tick = 1'b0; ifa.rand_num = '0;
        ifb.start = 1'b0; ifb.game_over = 1'b0; ifb.scroll_tick = 1'b0; ifb.rand_num = '0;
        cycle(3);
        rst = 1'b0;
        cycle(1);

        // Reset state
        check("rst_valid",   32'(ifa.pipe_valid), 32'd0);
        check("rst_score",   32'(ifa.score), 32'd0);
        check("rst_running", 32'(ifa.running), 32'd0);
        check("rst_pulse",   32'(ifa.score_pulse), 32'd0);
        check("rst_x0",      xa(0), 32'd0);

        // Full slots with SPACING=20: spawns on ticks 1,21,41,61
        ifb.start = 1'b1; cycle(1); ifb.start = 1'b0;
        ifb.rand_num = 10'h2AB;          // gap 80+0xAB = 251
        tick_b(61);
        check("b_full_at61", 32'(ifb.pipe_valid), 32'hF);
        check("b_x3_new",    xb(3), 32'd640);
        tick_b(20);                      // tick 81: no free slot, held
        check("b_full_at81", 32'(ifb.pipe_valid), 32'hF);
        tick_b(240);                     // tick 321: slot0 reaches x=0
        check("b_x0_zero",   xb(0), 32'd0);
        check("b_v0_at_x0",  32'(ifb.pipe_valid), 32'hF);
        check("b_score3",    32'(ifb.score), 32'd3);
        tick_b(1);                       // tick 322: retire + respawn into slot0
        check("b_x0_respawn", xb(0), 32'd640);
        check("b_g0_respawn", gb(0), 32'd251);
        check("b_x1_322",    xb(1), 32'd38);
        check("b_full_322",  32'(ifb.pipe_valid), 32'hF);
        tick_b(19);                      // tick 341
        check("b_x1_zero",   xb(1), 32'd0);
        tick_b(1);                       // tick 342
        check("b_x1_respawn", xb(1), 32'd640);
        check("b_x0_342",    xb(0), 32'd600);

        // Test 1: first tick after start spawns slot0
        ifa.start = 1'b1; cycle(1); ifa.start = 1'b0;
        check("t1_running",  32'(ifa.running), 32'd1);
        check("t1_valid_pre", 32'(ifa.pipe_valid), 32'd0);
        ifa.rand_num = 10'h3C5;
        tick_a(1);
        check("t1_valid",    32'(ifa.pipe_valid), 32'h1);
        check("t1_x0",       xa(0), 32'd640);
        check("t1_gap0",     ga(0), 32'd277);
        check("t1_score",    32'(ifa.score), 32'd0);

        // Test 2: second spawn on tick 111
        ifa.rand_num = 10'h005;
        tick_a(109);                     // tick 110
        check("t2_valid110", 32'(ifa.pipe_valid), 32'h1);
        check("t2_x0_110",   xa(0), 32'd422);
        cycle(2);                        // no tick: field holds
        check("t2_hold_x0",  xa(0), 32'd422);
        tick_a(1);                       // tick 111
        check("t2_valid111", 32'(ifa.pipe_valid), 32'h3);
        check("t2_x1",       xa(1), 32'd640);
        check("t2_gap1",     ga(1), 32'd85);
        check("t2_x0_111",   xa(0), 32'd420);

        // Test 3: slot0 passes the bird on tick 268 (x 108 -> 106)
        tick_a(156);                     // tick 267
        check("t3_x0_267",   xa(0), 32'd108);
        check("t3_score267", 32'(ifa.score), 32'd0);
        check("t3_pulse267", 32'(ifa.score_pulse), 32'd0);
        tick_a(1);                       // tick 268
        check("t3_pulse",    32'(ifa.score_pulse), 32'd1);
        check("t3_score",    32'(ifa.score), 32'd1);
        check("t3_x0_268",   xa(0), 32'd106);
        check("t3_valid",    32'(ifa.pipe_valid), 32'h7);
        cycle(1);
        check("t3_pulse_off", 32'(ifa.score_pulse), 32'd0);
        tick_a(1);                       // tick 269
        check("t3_no_repulse", 32'(ifa.score_pulse), 32'd0);
        check("t3_score_hold", 32'(ifa.score), 32'd1);

        // Test 5: game_over together with scroll_tick
        ifa.game_over = 1'b1;
        tick_a(1);
        ifa.game_over = 1'b0;
        check("t5_running",  32'(ifa.running), 32'd0);
        check("t5_x0_frozen", xa(0), 32'd104);
        tick_a(50);
        check("t5_x0_50",    xa(0), 32'd104);
        check("t5_score_50", 32'(ifa.score), 32'd1);
        check("t5_valid_50", 32'(ifa.pipe_valid), 32'h7);
        check("t5_run_50",   32'(ifa.running), 32'd0);
        ifa.start = 1'b1; cycle(1); ifa.start = 1'b0;
        check("t5_restart_valid", 32'(ifa.pipe_valid), 32'd0);
        check("t5_restart_score", 32'(ifa.score), 32'd0);
        check("t5_restart_run",   32'(ifa.running), 32'd1);
        tick_a(1);
        check("t5_respawn_valid", 32'(ifa.pipe_valid), 32'h1);
        check("t5_respawn_x0",    xa(0), 32'd640);
        check("t5_respawn_gap0",  ga(0), 32'd85);

        // start while running is ignored
        ifa.start = 1'b1; cycle(1); ifa.start = 1'b0;
        check("t5_start_ign", 32'(ifa.pipe_valid), 32'h1);

        // Test 6: reset with three pipes live
        tick_a(220);                     // tick 221 after restart
        check("t6_valid3",   32'(ifa.pipe_valid), 32'h7);
        check("t6_x0",       xa(0), 32'd200);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        check("t6_valid",    32'(ifa.pipe_valid), 32'd0);
        check("t6_x",        32'(ifa.pipe_x[31:0]), 32'd0);
        check("t6_gap",      32'(ifa.pipe_gap_top[29:0]), 32'd0);
        check("t6_score",    32'(ifa.score), 32'd0);
        check("t6_running",  32'(ifa.running), 32'd0);
        check("t6_b_valid",  32'(ifb.pipe_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
